// File: rtl/upsample_arb.sv
// upsample_arb: round-robin burst arbiter that time-shares one 4-in/8-out upsampler between NCHAN requesters.
// Optional per-channel accepted-beat counters are built when UPSAMPLE_ARB_STATS_EN is defined.
module upsample_arb #(
    parameter int NCHAN   = 4,
    parameter int LATENCY = 12,
    parameter int BURST   = 8,
    parameter int GUARD   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NCHAN-1:0]         req_i,
    input  logic [NCHAN*48-1:0]      dat_i,
    output logic [NCHAN-1:0]         gnt_o,
    output logic [47:0]              us_dat_o,
    input  logic [95:0]              us_dat_i,
    output logic [95:0]              dat_o,
    output logic                     valid_o,
    output logic [$clog2(NCHAN)-1:0] chan_o,
    output logic                     first_o,
    output logic [NCHAN*16-1:0]      beats_o
);
    localparam int CW = $clog2(NCHAN);
    localparam int TW = CW + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] owner_q, owner_d;
    logic [CW-1:0] rr_q, rr_d;
    logic          has_owner_q, has_owner_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    guard_q, guard_d;
    logic          first_pend_q, first_pend_d;
    logic [NCHAN-1:0] gnt_s;
    logic          acc_s;
    logic [CW:0]   pick_s;
    logic [TW-1:0] tag_s;
    logic [TW-1:0] pipe_q [LATENCY+1];
    logic [47:0]   us_dat_q;
    logic [95:0]   dat_q;
    logic          valid_q;
    logic [CW-1:0] chan_q;
    logic          first_q;

    // Returns {found, index} of the first requester strictly after rr, wrapping, rr itself last.
    function automatic logic [CW:0] pick_winner(input logic [NCHAN-1:0] req, input logic [CW-1:0] rr);
        logic [CW:0] res;
        int          j;
        res = '0;
        for (int i = NCHAN; i >= 1; i--) begin
            j = (int'(rr) + i) % NCHAN;
            if (req[j]) begin
                res = {1'b1, CW'(j)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration FSM next-state, grant and accept decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        has_owner_d  = has_owner_q;
        cnt_d        = cnt_q;
        guard_d      = guard_q;
        first_pend_d = first_pend_q;
        gnt_s        = '0;
        acc_s        = 1'b0;
        pick_s       = pick_winner(req_i, rr_q);
        case (state_q)
            S_IDLE: begin
                if (pick_s[CW]) begin
                    owner_d     = pick_s[CW-1:0];
                    has_owner_d = 1'b1;
                    if (has_owner_q && (pick_s[CW-1:0] != owner_q) && (GUARD > 0)) begin
                        state_d = S_FLUSH;
                        guard_d = 4'(GUARD);
                    end else begin
                        state_d      = S_GRANT;
                        cnt_d        = 8'd0;
                        first_pend_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (req_i[owner_q]) begin
                    gnt_s[owner_q] = 1'b1;
                    acc_s          = 1'b1;
                    first_pend_d   = 1'b0;
                    if (cnt_q == 8'(BURST - 1)) begin
                        state_d = S_IDLE;
                        rr_d    = owner_q;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // Owner went quiet: burst ends without charging a gap beat.
                    state_d = S_IDLE;
                    rr_d    = owner_q;
                end
            end
            S_FLUSH: begin
                if (guard_q <= 4'd1) begin
                    state_d      = S_GRANT;
                    cnt_d        = 8'd0;
                    first_pend_d = 1'b1;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tag_s = acc_s ? {1'b1, owner_q, first_pend_q} : {TW{1'b0}};
    assign gnt_o = gnt_s;

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            rr_q         <= CW'(NCHAN - 1);
            has_owner_q  <= 1'b0;
            cnt_q        <= 8'd0;
            guard_q      <= 4'd0;
            first_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            has_owner_q  <= has_owner_d;
            cnt_q        <= cnt_d;
            guard_q      <= guard_d;
            first_pend_q <= first_pend_d;
        end
    end

    // Upsampler feed, tag pipe travelling alongside it, and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            us_dat_q <= 48'h0;
            for (int i = 0; i <= LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            dat_q   <= 96'h0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            first_q <= 1'b0;
        end else begin
            us_dat_q  <= acc_s ? dat_i[int'(owner_q)*48 +: 48] : 48'h0;
            pipe_q[0] <= tag_s;
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            dat_q                       <= us_dat_i;
            {valid_q, chan_q, first_q}  <= pipe_q[LATENCY];
        end
    end

    assign us_dat_o = us_dat_q;
    assign dat_o    = dat_q;
    assign valid_o  = valid_q;
    assign chan_o   = chan_q;
    assign first_o  = first_q;

`ifdef UPSAMPLE_ARB_STATS_EN
    logic [NCHAN*16-1:0] beats_q;

    // Saturating accepted-beat counter per channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beats_q <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (gnt_s[k] && (beats_q[16*k +: 16] != 16'hFFFF)) begin
                    beats_q[16*k +: 16] <= beats_q[16*k +: 16] + 16'd1;
                end
            end
        end
    end

    assign beats_o = beats_q;
`else
    assign beats_o = '0;
`endif

endmodule

// File: tb/tb_upsample_arb.sv
// Scoreboard bench for upsample_arb: a turn-based arbitration model predicts grants and tagged outputs.
module tb_upsample_arb;
    localparam int NCHAN   = 4;
    localparam int LATENCY = 12;
    localparam int BURST   = 8;
    localparam int GUARD   = 2;
    localparam int BOUND   = (NCHAN - 1) * (BURST + GUARD + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCHAN-1:0]     req_i = '0;
    logic [NCHAN*48-1:0]  dat_i = '0;
    logic [NCHAN-1:0]     gnt_o;
    logic [47:0]          us_dat_o;
    logic [95:0]          us_dat_i;
    logic [95:0]          dat_o;
    logic                 valid_o;
    logic [1:0]           chan_o;
    logic                 first_o;
    logic [NCHAN*16-1:0]  beats_o;

    upsample_arb #(.NCHAN(NCHAN), .LATENCY(LATENCY), .BURST(BURST), .GUARD(GUARD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .dat_i(dat_i), .gnt_o(gnt_o),
        .us_dat_o(us_dat_o), .us_dat_i(us_dat_i), .dat_o(dat_o), .valid_o(valid_o),
        .chan_o(chan_o), .first_o(first_o), .beats_o(beats_o)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] dup(input logic [47:0] f);
        logic [95:0] r;
        for (int i = 0; i < 4; i++) begin
            r[24*i +: 12]      = f[12*i +: 12];
            r[24*i + 12 +: 12] = f[12*i +: 12];
        end
        return r;
    endfunction

    // Upsampler stand-in: LATENCY-deep delay that doubles every sample.
    logic [95:0] ups_q [LATENCY];
    initial for (int i = 0; i < LATENCY; i++) ups_q[i] = '0;
    always @(posedge clk) begin
        ups_q[0] <= dup(us_dat_o);
        for (int i = 1; i < LATENCY; i++) ups_q[i] <= ups_q[i-1];
    end
    assign us_dat_i = ups_q[LATENCY-1];

    typedef struct { int chan; bit first; logic [95:0] data; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0, errors = 0, cyc = 0;
    int pending [NCHAN];
    logic [47:0] frame [NCHAN];
    bit pause [NCHAN];
    bit pause_en = 1'b0;
    int acc_ch = -1;

    // Reference model: who is being served, how many beats remain, how many flush beats remain.
    int serving, gap, owner, have_owner, rr, left, mfirst, win, maxwait;
    int wait_cnt [NCHAN];
    int mcount [NCHAN];
    logic [47:0] exp_us;
    logic [NCHAN-1:0] exp_gnt;
    logic [63:0] exp_beats;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("valid_in_reset", 128'(valid_o), 128'd0);
            chk("gnt_in_reset", 128'(gnt_o), 128'd0);
            serving = 0; gap = 0; owner = 0; have_owner = 0; rr = NCHAN - 1; left = 0; mfirst = 0;
            exp_q.delete();
            exp_us = '0;
            acc_ch = -1;
            for (int k = 0; k < NCHAN; k++) begin wait_cnt[k] = 0; mcount[k] = 0; end
        end else begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 128'(valid_o), 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dat_o", 128'(dat_o), 128'(mon_e.data));
                    chk("chan_o", 128'(chan_o), 128'(mon_e.chan));
                    chk("first_o", 128'(first_o), 128'(mon_e.first));
                    chk("latency", 128'(cyc - mon_e.cyc), 128'(LATENCY + 1));
                end
            end else if (exp_q.size() > 0 && (cyc - exp_q[0].cyc) > LATENCY + 1) begin
                chk("missing_valid", 128'(valid_o), 128'd1);
                void'(exp_q.pop_front());
            end
            chk("us_dat_o", 128'(us_dat_o), 128'(exp_us));
`ifdef UPSAMPLE_ARB_STATS_EN
            for (int k = 0; k < NCHAN; k++) exp_beats[16*k +: 16] = 16'(mcount[k]);
            chk("beats_o", 128'(beats_o), 128'(exp_beats));
`else
            chk("beats_zero", 128'(beats_o), 128'd0);
`endif
            exp_gnt = '0;
            acc_ch  = -1;
            if (serving != 0 && req_i[owner]) begin
                exp_gnt[owner] = 1'b1;
                acc_ch = owner;
            end
            chk("gnt_o", 128'(gnt_o), 128'(exp_gnt));
            for (int k = 0; k < NCHAN; k++) begin
                if (req_i[k] && owner != k) wait_cnt[k]++;
                else wait_cnt[k] = 0;
                if (wait_cnt[k] > maxwait) maxwait = wait_cnt[k];
            end
            if (acc_ch >= 0) begin
                exp_q.push_back('{owner, mfirst[0], dup(frame[owner]), cyc + 1});
                exp_us = frame[owner];
                if (mcount[owner] < 65535) mcount[owner]++;
            end else begin
                exp_us = '0;
            end
            if (serving != 0) begin
                if (acc_ch >= 0) begin
                    mfirst = 0;
                    left--;
                    if (left == 0) begin serving = 0; rr = owner; end
                end else begin
                    serving = 0; rr = owner;
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) begin serving = 1; left = BURST; mfirst = 1; end
            end else begin
                win = -1;
                for (int i = 1; i <= NCHAN; i++)
                    if (win < 0 && req_i[(rr + i) % NCHAN]) win = (rr + i) % NCHAN;
                if (win >= 0) begin
                    if (have_owner != 0 && win != owner && GUARD > 0) gap = GUARD;
                    else begin serving = 1; left = BURST; mfirst = 1; end
                    owner = win;
                    have_owner = 1;
                end
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < NCHAN; k++) begin
            req_i[k] = (pending[k] > 0) && !pause[k];
            dat_i[48*k +: 48] = frame[k];
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (acc_ch >= 0) begin
            pending[acc_ch]--;
            frame[acc_ch] = 48'({$urandom(), $urandom()});
        end
        for (int k = 0; k < NCHAN; k++) pause[k] = pause_en && ($urandom_range(0, 7) == 0);
        drive();
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() > 0);
        for (int k = 0; k < NCHAN; k++) if (pending[k] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin step(); n++; end
        chk(name, 128'(n < budget), 128'd1);
        repeat (3) step();
    endtask

    initial begin
        int n;
        maxwait = 0;
        for (int k = 0; k < NCHAN; k++) begin
            pending[k] = 0; pause[k] = 1'b0;
            frame[k] = 48'({$urandom(), $urandom()});
        end
        drive();
        repeat (3) step();
        chk("rst_gnt", 128'(gnt_o), 128'd0);
        chk("rst_us_dat", 128'(us_dat_o), 128'd0);
        chk("rst_valid", 128'(valid_o), 128'd0);
        chk("rst_chan", 128'(chan_o), 128'd0);
        chk("rst_first", 128'(first_o), 128'd0);
        chk("rst_dat", 128'(dat_o), 128'd0);
        rst_n = 1'b1;

        pending[0] = 5;                         drain("drain_single", 200);
        pending[0] = 20; pending[1] = 20;       drain("drain_pair", 400);
        pending[2] = 20;                        drain("drain_lone", 200);
        for (int k = 0; k < NCHAN; k++) pending[k] = 24;
        drain("drain_all", 800);

        // Reset while beats are in flight.
        for (int k = 0; k < NCHAN; k++) pending[k] = 10;
        n = 0;
        while (exp_q.size() < 6 && n < 100) begin step(); n++; end
        chk("inflight_wait", 128'(n < 100), 128'd1);
        rst_n = 1'b0;
        #1 chk("valid_async_clear", 128'(valid_o), 128'd0);
        repeat (3) step();
        rst_n = 1'b1;
        drain("drain_after_reset", 600);

        pause_en = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) pending[$urandom_range(0, NCHAN - 1)] += $urandom_range(1, 12);
            step();
        end
        pause_en = 1'b0;
        drain("drain_random", 1500);

`ifdef UPSAMPLE_ARB_STATS_EN
        pending[1] = 66000;
        drain("drain_stats", 80000);
        chk("beats_sat", 128'(beats_o[31:16]), 128'hFFFF);
`endif
        chk("starvation_bound", 128'(maxwait <= BOUND), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
